// File: rtl/wb_writeback.sv
// wb_writeback: write-back stage of the 5-stage MIPS pipeline.
//
// Purpose:
//   Filters and extends the raw data-memory word (byte / halfword / word,
//   signed or unsigned). Picks the register-file write value by a fixed
//   priority: JAL link address, then LUI immediate, then load data, then
//   ALU result. Registers the write value, the filtered load value and the
//   destination index. There is one cycle of latency and no stall input.
//
// Ports:
//   i_clk                  clock; all state updates on the rising edge
//   i_reset                synchronous reset, active low; clears all outputs
//   MEM_WB_LUI             instruction is LUI
//   MEM_WB_Extension       sign-extended immediate; LUI uses bits [15:0]
//   MEM_WB_DatoMemoria     raw word read from data memory
//   MEM_WB_TamanoFiltroL   load size: 00 byte, 01 halfword, 1x word
//   MEM_WB_ZeroExtend      1 = zero-extend a narrow load, 0 = sign-extend
//   MEM_WB_MemToReg        1 = write load data, 0 = write ALU result
//   MEM_WB_ALU             ALU result
//   MEM_WB_JAL             instruction is JAL/JALR; write the link address
//   MEM_WB_PC8             link address (PC+8)
//   MEM_WB_RegistroDestino destination register index
//   MEM_WB_Offset          (WB_LOAD_OFFSET_EN only) byte offset of the load
//   WB_DatoEscritura_o     final register-file write data
//   WB_EscribirDato_o      filtered/extended load data, always the load path
//   WB_RegistroDestino_o   registered destination register index
//
// Optional feature macro: WB_LOAD_OFFSET_EN
//   When defined, narrow loads pick their lane from MEM_WB_Offset.
//   When undefined, the port is absent and narrow loads use lane 0.
module wb_writeback #(
  parameter int NBITS     = 32,
  parameter int HWORDBITS = 16,
  parameter int BYTENBITS = 8,
  parameter int REGS      = 5,
  parameter int TNBITS    = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              MEM_WB_LUI,
  input  logic [NBITS-1:0]  MEM_WB_Extension,
  input  logic [NBITS-1:0]  MEM_WB_DatoMemoria,
  input  logic [TNBITS-1:0] MEM_WB_TamanoFiltroL,
  input  logic              MEM_WB_ZeroExtend,
  input  logic              MEM_WB_MemToReg,
  input  logic [NBITS-1:0]  MEM_WB_ALU,
  input  logic              MEM_WB_JAL,
  input  logic [NBITS-1:0]  MEM_WB_PC8,
  input  logic [REGS-1:0]   MEM_WB_RegistroDestino,
`ifdef WB_LOAD_OFFSET_EN
  input  logic [1:0]        MEM_WB_Offset,
`endif
  output logic [NBITS-1:0]  WB_DatoEscritura_o,
  output logic [NBITS-1:0]  WB_EscribirDato_o,
  output logic [REGS-1:0]   WB_RegistroDestino_o
);

  localparam int NLANES = NBITS / BYTENBITS;

  logic [BYTENBITS-1:0] selByte;
  logic [HWORDBITS-1:0] selHalf;
  logic [NBITS-1:0]     loadData_next;
  logic [NBITS-1:0]     writeData_next;
  logic [NBITS-1:0]     writeData_reg;
  logic [NBITS-1:0]     loadData_reg;
  logic [REGS-1:0]      destReg_reg;
  logic                 fillBit;

  // Only the low half of the immediate matters for LUI.
  logic unusedExtensionBits;
  assign unusedExtensionBits = ^MEM_WB_Extension[NBITS-1:HWORDBITS];

`ifdef WB_LOAD_OFFSET_EN
  logic [BYTENBITS-1:0] byteLane [NLANES];

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : gByteLane
      assign byteLane[gi] = MEM_WB_DatoMemoria[gi*BYTENBITS +: BYTENBITS];
    end
  endgenerate

  // Halfword loads are aligned, so only Offset[1] picks the half.
  assign selByte = byteLane[MEM_WB_Offset];
  assign selHalf = MEM_WB_Offset[1] ? MEM_WB_DatoMemoria[NBITS-1 -: HWORDBITS]
                                    : MEM_WB_DatoMemoria[HWORDBITS-1:0];
`else
  assign selByte = MEM_WB_DatoMemoria[BYTENBITS-1:0];
  assign selHalf = MEM_WB_DatoMemoria[HWORDBITS-1:0];
`endif

  // Load filter. A narrow load fills its upper bits with 0 or with the MSB
  // of the selected field. A word load passes straight through.
  always_comb begin
    loadData_next = MEM_WB_DatoMemoria;
    fillBit       = 1'b0;
    case (MEM_WB_TamanoFiltroL)
      2'b00: begin
        fillBit       = ~MEM_WB_ZeroExtend & selByte[BYTENBITS-1];
        loadData_next = {{(NBITS-BYTENBITS){fillBit}}, selByte};
      end
      2'b01: begin
        fillBit       = ~MEM_WB_ZeroExtend & selHalf[HWORDBITS-1];
        loadData_next = {{(NBITS-HWORDBITS){fillBit}}, selHalf};
      end
      default: loadData_next = MEM_WB_DatoMemoria;
    endcase
  end

  // Write-data priority mux. If several selects are set, the first match wins.
  always_comb begin
    writeData_next = MEM_WB_ALU;
    if (MEM_WB_JAL)
      writeData_next = MEM_WB_PC8;
    else if (MEM_WB_LUI)
      writeData_next = {MEM_WB_Extension[HWORDBITS-1:0], {(NBITS-HWORDBITS){1'b0}}};
    else if (MEM_WB_MemToReg)
      writeData_next = loadData_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      writeData_reg <= '0;
      loadData_reg  <= '0;
      destReg_reg   <= '0;
    end else begin
      writeData_reg <= writeData_next;
      loadData_reg  <= loadData_next;
      destReg_reg   <= MEM_WB_RegistroDestino;
    end
  end

  assign WB_DatoEscritura_o   = writeData_reg;
  assign WB_EscribirDato_o    = loadData_reg;
  assign WB_RegistroDestino_o = destReg_reg;

endmodule

// File: tb/tb_wb_writeback.sv
// Scoreboard bench for wb_writeback. The driver applies one directed vector
// per cycle on the falling edge and pushes its hand-computed expected outputs.
// The monitor pops one entry just after each rising edge and compares it.
module tb_wb_writeback;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        lui, zext, memToReg, jal;
  logic [31:0] extension, datoMem, alu, pc8;
  logic [1:0]  tamano;
  logic [4:0]  dest;
  logic [31:0] datoEscritura, escribirDato;
  logic [4:0]  regDest;
`ifdef WB_LOAD_OFFSET_EN
  logic [1:0]  offset;
`endif

  typedef struct {
    string       name;
    logic [31:0] expW;
    logic [31:0] expE;
    logic [4:0]  expD;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 i_clk = ~i_clk;

  wb_writeback dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .MEM_WB_LUI             (lui),
    .MEM_WB_Extension       (extension),
    .MEM_WB_DatoMemoria     (datoMem),
    .MEM_WB_TamanoFiltroL   (tamano),
    .MEM_WB_ZeroExtend      (zext),
    .MEM_WB_MemToReg        (memToReg),
    .MEM_WB_ALU             (alu),
    .MEM_WB_JAL             (jal),
    .MEM_WB_PC8             (pc8),
    .MEM_WB_RegistroDestino (dest),
`ifdef WB_LOAD_OFFSET_EN
    .MEM_WB_Offset          (offset),
`endif
    .WB_DatoEscritura_o     (datoEscritura),
    .WB_EscribirDato_o      (escribirDato),
    .WB_RegistroDestino_o   (regDest)
  );

  // Monitor: pops one expectation per rising edge while any are pending.
  always @(posedge i_clk) begin
    #1;
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checks += 3;
      if (datoEscritura !== e.expW) begin
        failures++;
        $display("FAIL %s DatoEscritura got %08h want %08h", e.name, datoEscritura, e.expW);
      end
      if (escribirDato !== e.expE) begin
        failures++;
        $display("FAIL %s EscribirDato got %08h want %08h", e.name, escribirDato, e.expE);
      end
      if (regDest !== e.expD) begin
        failures++;
        $display("FAIL %s RegistroDestino got %0d want %0d", e.name, regDest, e.expD);
      end
      $display("txn %-14s W=%08h E=%08h D=%0d", e.name, datoEscritura, escribirDato, regDest);
    end
  end

  task automatic drive(input string name, input logic rst, input logic j, input logic l,
                       input logic m, input logic [1:0] t, input logic z,
                       input logic [31:0] ext, input logic [31:0] dm, input logic [31:0] a,
                       input logic [31:0] p, input logic [4:0] d, input logic [1:0] off,
                       input logic [31:0] expW, input logic [31:0] expE, input logic [4:0] expD);
    exp_t e;
    @(negedge i_clk);
    i_reset = rst; jal = j; lui = l; memToReg = m; tamano = t; zext = z;
    extension = ext; datoMem = dm; alu = a; pc8 = p; dest = d;
`ifdef WB_LOAD_OFFSET_EN
    offset = off;
`endif
    e.name = name; e.expW = expW; e.expE = expE; e.expD = expD;
    expQ.push_back(e);
  endtask

  localparam logic [31:0] DM = 32'hCAFE_F08A;

  initial begin
    // Reset held for two edges with busy inputs: outputs stay zero.
    drive("reset0", 0, 1, 1, 1, 2'b10, 0, 32'hFFFF_ABCD, DM, 32'hDEAD_BEEF, 32'h1, 5'd7, 2'd0,
          32'h0, 32'h0, 5'd0);
    drive("reset1", 0, 0, 0, 0, 2'b00, 0, 32'h0, DM, 32'hDEAD_BEEF, 32'h1, 5'd7, 2'd0,
          32'h0, 32'h0, 5'd0);
    // First edge after release already follows the inputs.
    drive("alu_path", 1, 0, 0, 0, 2'b10, 0, 32'h0, DM, 32'h1234_5678, 32'h0, 5'd5, 2'd0,
          32'h1234_5678, 32'hCAFE_F08A, 5'd5);
    drive("byte_signed", 1, 0, 0, 1, 2'b00, 0, 32'h0, DM, 32'h1, 32'h0, 5'd6, 2'd0,
          32'hFFFF_FF8A, 32'hFFFF_FF8A, 5'd6);
    drive("byte_unsigned", 1, 0, 0, 1, 2'b00, 1, 32'h0, DM, 32'h1, 32'h0, 5'd8, 2'd0,
          32'h0000_008A, 32'h0000_008A, 5'd8);
    drive("half_signed", 1, 0, 0, 1, 2'b01, 0, 32'h0, DM, 32'h1, 32'h0, 5'd9, 2'd0,
          32'hFFFF_F08A, 32'hFFFF_F08A, 5'd9);
    drive("half_unsigned", 1, 0, 0, 1, 2'b01, 1, 32'h0, DM, 32'h1, 32'h0, 5'd10, 2'd0,
          32'h0000_F08A, 32'h0000_F08A, 5'd10);
    drive("word_zext", 1, 0, 0, 1, 2'b10, 1, 32'h0, DM, 32'h1, 32'h0, 5'd11, 2'd0,
          32'hCAFE_F08A, 32'hCAFE_F08A, 5'd11);
    drive("lui_over_mem", 1, 0, 1, 1, 2'b00, 0, 32'hFFFF_ABCD, DM, 32'h1, 32'h0, 5'd12, 2'd0,
          32'hABCD_0000, 32'hFFFF_FF8A, 5'd12);
    drive("jal_priority", 1, 1, 1, 1, 2'b01, 1, 32'hFFFF_ABCD, DM, 32'h1, 32'h0040_0010, 5'd31, 2'd0,
          32'h0040_0010, 32'h0000_F08A, 5'd31);
    // Reset in mid-stream discards that edge's sample.
    drive("reset_mid", 0, 1, 1, 1, 2'b01, 1, 32'hFFFF_ABCD, DM, 32'h1, 32'h0040_0010, 5'd31, 2'd0,
          32'h0, 32'h0, 5'd0);
    drive("word_tam11", 1, 0, 0, 0, 2'b11, 0, 32'h0, DM, 32'hFFFF_FFFF, 32'h0, 5'd31, 2'd0,
          32'hFFFF_FFFF, 32'hCAFE_F08A, 5'd31);
    drive("mem_word11", 1, 0, 0, 1, 2'b11, 0, 32'h0, 32'h8000_0001, 32'h5, 32'h0, 5'd1, 2'd0,
          32'h8000_0001, 32'h8000_0001, 5'd1);
`ifdef WB_LOAD_OFFSET_EN
    drive("byte_u_off3", 1, 0, 0, 1, 2'b00, 1, 32'h0, DM, 32'h1, 32'h0, 5'd2, 2'd3,
          32'h0000_00CA, 32'h0000_00CA, 5'd2);
    drive("half_s_off2", 1, 0, 0, 1, 2'b01, 0, 32'h0, DM, 32'h1, 32'h0, 5'd3, 2'd2,
          32'hFFFF_CAFE, 32'hFFFF_CAFE, 5'd3);
    drive("byte_s_off1", 1, 0, 0, 1, 2'b00, 0, 32'h0, DM, 32'h1, 32'h0, 5'd4, 2'd1,
          32'hFFFF_FFF0, 32'hFFFF_FFF0, 5'd4);
    drive("half_u_off3", 1, 0, 0, 1, 2'b01, 1, 32'h0, DM, 32'h1, 32'h0, 5'd4, 2'd3,
          32'h0000_CAFE, 32'h0000_CAFE, 5'd4);
    drive("word_off1", 1, 0, 0, 1, 2'b10, 0, 32'h0, DM, 32'h1, 32'h0, 5'd4, 2'd1,
          32'hCAFE_F08A, 32'hCAFE_F08A, 5'd4);
`endif
    // Drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge i_clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain pending got %0d want 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
